// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for a 5-stage pipeline. Produces
//                latch/PC enables and bubble flushes from data-memory waits,
//                halt, taken branches, load-use dependencies, jumps and
//                instruction-fetch misses. Tracks fetch stall cycles and a
//                sticky data-wait watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        mem_halt,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_regDst,
    input  logic        ex_branch_taken,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_useRt,
    input  logic        id_jump,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        halt,
    output logic [2:0]  state,
    output logic [15:0] stall_cnt,
    output logic        dwait_timeout
);

    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_DWAIT  = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_HALTED = 3'd3;

    localparam logic [7:0]  C_DWAIT_MAX = 8'hFF;
    localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

    logic [2:0]  state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  dwait_cnt_q, dwait_cnt_d;
    logic        dwait_timeout_q, dwait_timeout_d;
    logic        halt_q, halt_d;

    logic        w_dpend;
    logic        w_lu;

    // Hazard detection: outstanding data access and load-use dependency
    always_comb begin
        w_dpend = (mem_dREN | mem_dWEN) & ~dhit;
        w_lu    = ex_dREN & (ex_regDst != 5'd0) &
                  ((ex_regDst == id_rs) | (id_useRt & (ex_regDst == id_rt)));
    end

    // Enables, flushes and next state; RUN and DWAIT share one priority chain
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;

        if (RST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_DRAIN: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                    state_d = ST_HALTED;
                end
                ST_HALTED: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                    state_d = ST_HALTED;
                end
                // RUN, DWAIT and the unreachable codes 4-7 all use RUN rules
                default: begin
                    if (w_dpend) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                        state_d = ST_DWAIT;
                    end else if (mem_halt) begin
                        pc_en = 1'b0;
                        {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                        state_d = ST_DRAIN;
                    end else if (ex_branch_taken) begin
                        // Branch outranks load-use and fetch miss: the
                        // dependant instruction is squashed anyway.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        state_d    = ST_RUN;
                    end else if (w_lu) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        state_d    = ST_RUN;
                    end else if (id_jump) begin
                        ifid_flush = 1'b1;
                        state_d    = ST_RUN;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        state_d    = ST_RUN;
                    end
                end
            endcase
        end
    end

    // Counter and flag next-state: stall count, data-wait watchdog, halt
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (state_q != ST_HALTED) && (stall_cnt_q != C_STALL_MAX))
            stall_cnt_d = stall_cnt_q + 16'd1;

        // Count only cycles that stay in DWAIT; any exit clears the count
        if ((state_q == ST_DWAIT) && w_dpend)
            dwait_cnt_d = (dwait_cnt_q == C_DWAIT_MAX) ? C_DWAIT_MAX
                                                       : dwait_cnt_q + 8'd1;
        else
            dwait_cnt_d = 8'd0;

        dwait_timeout_d = dwait_timeout_q | (dwait_cnt_d == C_DWAIT_MAX);
        halt_d          = (state_d == ST_HALTED);
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_RUN;
            stall_cnt_q     <= 16'd0;
            dwait_cnt_q     <= 8'd0;
            dwait_timeout_q <= 1'b0;
            halt_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            stall_cnt_q     <= stall_cnt_d;
            dwait_cnt_q     <= dwait_cnt_d;
            dwait_timeout_q <= dwait_timeout_d;
            halt_q          <= halt_d;
        end
    end

    // halt is forced low while reset is held, even from HALTED
    always_comb begin
        halt          = halt_q & ~RST;
        state         = state_q;
        stall_cnt     = stall_cnt_q;
        dwait_timeout = dwait_timeout_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: directed sequences with
//                literal expectations plus randomized traffic compared every
//                cycle against a rule-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, mem_dREN, mem_dWEN, mem_halt;
    logic        ex_dREN, ex_branch_taken, id_useRt, id_jump;
    logic [4:0]  ex_regDst, id_rs, id_rt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, halt, dwait_timeout;
    logic [2:0]  state;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
        .ex_dREN(ex_dREN), .ex_regDst(ex_regDst),
        .ex_branch_taken(ex_branch_taken), .id_rs(id_rs), .id_rt(id_rt),
        .id_useRt(id_useRt), .id_jump(id_jump),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halt(halt), .state(state),
        .stall_cnt(stall_cnt), .dwait_timeout(dwait_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 running, 1 waiting on data memory, 2 draining, 3 halted
    int   m_mode   = 0;
    int   m_stall  = 0;
    int   m_waits  = 0;
    bit   m_to     = 0;
    bit   m_valid  = 0;

    // Returns {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl,exmem_fl}
    function automatic logic [7:0] expect_ctl(input int mode);
        bit dp, lu;
        if (RST) return 8'b00000_111;
        if (mode >= 2) return 8'b00000_000;
        dp = (mem_dREN || mem_dWEN) && !dhit;
        lu = ex_dREN && ex_regDst != 0 &&
             (ex_regDst == id_rs || (id_useRt && ex_regDst == id_rt));
        if (dp)              return 8'b00000_000;
        if (mem_halt)        return 8'b01111_111;
        if (ex_branch_taken) return 8'b11111_110;
        if (lu)              return 8'b00111_010;
        if (id_jump)         return 8'b11111_100;
        if (!ihit)           return 8'b01111_100;
        return 8'b11111_000;
    endfunction

    // Per-cycle compare, then advance the model with the sampled inputs
    always @(negedge CLK) begin
        logic [7:0] e;
        bit dp;
        e = expect_ctl(m_mode);
        if (m_valid) begin
            check("model_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e[7:3]);
            check("model_flushes", {ifid_flush, idex_flush, exmem_flush}, e[2:0]);
            check("model_state", state, m_mode);
            check("model_halt", halt, (m_mode == 3 && !RST));
            check("model_stall_cnt", stall_cnt, m_stall);
            check("model_timeout", dwait_timeout, m_to);
        end
        dp = (mem_dREN || mem_dWEN) && !dhit;
        if (RST) begin
            m_mode = 0; m_stall = 0; m_waits = 0; m_to = 0; m_valid = 1;
        end else begin
            if (!e[7] && m_mode != 3 && m_stall < 65535) m_stall++;
            if (m_mode == 1 && dp) begin
                if (m_waits < 255) m_waits++;
            end else m_waits = 0;
            if (m_waits >= 255) m_to = 1;
            if (m_mode == 2 || m_mode == 3) m_mode = 3;
            else if (dp)        m_mode = 1;
            else if (mem_halt)  m_mode = 2;
            else                m_mode = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_halt = 0;
        ex_dREN = 0; ex_regDst = 0; ex_branch_taken = 0;
        id_rs = 0; id_rt = 0; id_useRt = 0; id_jump = 0;
    endtask

    task automatic to_neg();
        @(negedge CLK);
    endtask

    task automatic to_next();
        @(posedge CLK); #1;
    endtask

    initial begin
        idle();
        RST = 1;
        to_neg();
        check("rst_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
        check("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        check("rst_halt", halt, 0);
        to_next(); to_next();
        RST = 0;
        to_neg();
        check("post_rst_state", state, 0);
        check("post_rst_stall", stall_cnt, 0);
        check("idle_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
        check("idle_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b000);
        to_next(); to_next(); to_next();
        to_neg();
        check("idle_stall_cnt", stall_cnt, 0);
        to_next();

        // Load-use bubble
        ex_dREN = 1; ex_regDst = 5; id_rs = 5;
        to_neg();
        check("lu_pc_ifid", {pc_en, ifid_en}, 2'b00);
        check("lu_idex_flush", idex_flush, 1);
        to_next(); idle();
        to_neg();
        check("lu_stall_cnt", stall_cnt, 1);
        to_next();
        ex_dREN = 1; ex_regDst = 0; id_rs = 0;
        to_neg();
        check("lu_r0_pc_en", pc_en, 1);
        to_next(); idle();

        // Branch outranks load-use and fetch miss
        ex_branch_taken = 1; ex_dREN = 1; ex_regDst = 7; id_rs = 7; ihit = 0;
        to_neg();
        check("br_enables", {pc_en, ifid_en}, 2'b11);
        check("br_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b110);
        to_next(); idle();

        // Data wait: three miss cycles then a hit
        mem_dREN = 1;
        to_neg();
        check("dw0_state", state, 0);
        check("dw0_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
        to_next(); to_neg();
        check("dw1_state", state, 1);
        to_next(); to_neg();
        check("dw2_state", state, 1);
        to_next(); dhit = 1;
        to_neg();
        check("dw_hit_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
        to_next(); idle();
        to_neg();
        check("dw_exit_state", state, 0);
        check("dw_stall_cnt", stall_cnt, 4);
        to_next();

        // Halt sequence then reset out of HALTED
        mem_halt = 1;
        to_neg();
        check("mh_ctl", {pc_en, memwb_en, ifid_flush, idex_flush, exmem_flush}, 5'b01111);
        to_next(); idle();
        to_neg();
        check("drain_state", state, 2);
        check("drain_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
        to_next(); to_neg();
        check("halted_state", state, 3);
        check("halted_halt", halt, 1);
        to_next(); ihit = 0; id_jump = 1; to_neg();
        check("halted_hold", {halt, pc_en, stall_cnt}, {1'b1, 1'b0, 16'd6});
        to_next(); idle(); RST = 1;
        to_neg();
        check("halted_rst_halt", halt, 0);
        to_next(); RST = 0;
        to_neg();
        check("after_halt_rst", {state, halt, stall_cnt}, {3'd0, 1'b0, 16'd0});
        to_next();

        // Watchdog: long store miss
        mem_dWEN = 1;
        for (int k = 1; k <= 260; k++) begin
            to_neg();
            if (k == 256) check("wd_before", dwait_timeout, 0);
            if (k == 257) check("wd_set", dwait_timeout, 1);
            to_next();
        end
        dhit = 1;
        to_next(); idle(); to_next();
        to_neg();
        check("wd_sticky", {dwait_timeout, state}, {1'b1, 3'd0});
        to_next(); RST = 1; to_next(); RST = 0;
        to_neg();
        check("wd_cleared", dwait_timeout, 0);
        to_next();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            RST             = ($urandom_range(0, 59) == 0);
            ihit            = ($urandom_range(0, 3) != 0);
            dhit            = $urandom_range(0, 1);
            mem_dREN        = ($urandom_range(0, 3) == 0);
            mem_dWEN        = ($urandom_range(0, 5) == 0);
            mem_halt        = ($urandom_range(0, 29) == 0);
            ex_dREN         = $urandom_range(0, 1);
            ex_regDst       = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_useRt        = $urandom_range(0, 1);
            id_jump         = ($urandom_range(0, 5) == 0);
            to_next();
        end
        idle(); RST = 0;
        to_neg();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
